// File: rtl/time_counter.sv
// Time-of-day counter (hh:mm:ss) advanced by one-second ticks, with validated
// preset loading and single-cycle carry pulses for minute, hour and day rollover.
module time_counter #(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  i_tick,
    input  logic                  i_load,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    output logic [P_SEC_BIT-1:0]  o_sec,
    output logic [P_MIN_BIT-1:0]  o_min,
    output logic [P_HOUR_BIT-1:0] o_hour,
    output logic                  o_min_tick,
    output logic                  o_hour_tick,
    output logic                  o_day_tick,
    output logic                  o_load_err
);

    localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);

    logic [P_SEC_BIT-1:0]  sec_q,  sec_d;
    logic [P_MIN_BIT-1:0]  min_q,  min_d;
    logic [P_HOUR_BIT-1:0] hour_q, hour_d;
    logic                  min_tick_q,  min_tick_d;
    logic                  hour_tick_q, hour_tick_d;
    logic                  day_tick_q,  day_tick_d;
    logic                  load_err_q,  load_err_d;

    logic load_legal;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign load_legal = (i_sec <= SEC_MAX) && (i_min <= MIN_MAX) && (i_hour <= HOUR_MAX);

    // Wrap on >= rather than == so a field can never escape its legal range.
    assign sec_wrap  = (sec_q  >= SEC_MAX);
    assign min_wrap  = (min_q  >= MIN_MAX);
    assign hour_wrap = (hour_q >= HOUR_MAX);

    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        load_err_d  = 1'b0;

        // A load, legal or not, always consumes the cycle's tick.
        if (i_load) begin
            if (load_legal) begin
                sec_d  = i_sec;
                min_d  = i_min;
                hour_d = i_hour;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en && i_tick) begin
            if (!sec_wrap) begin
                sec_d = sec_q + P_SEC_BIT'(1);
            end else begin
                sec_d      = '0;
                min_tick_d = 1'b1;
                if (!min_wrap) begin
                    min_d = min_q + P_MIN_BIT'(1);
                end else begin
                    min_d       = '0;
                    hour_tick_d = 1'b1;
                    if (!hour_wrap) begin
                        hour_d = hour_q + P_HOUR_BIT'(1);
                    end else begin
                        hour_d     = '0;
                        day_tick_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
            load_err_q  <= load_err_d;
        end
    end

    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_min_tick  = min_tick_q;
    assign o_hour_tick = hour_tick_q;
    assign o_day_tick  = day_tick_q;
    assign o_load_err  = load_err_q;

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter P_SEC_BIT, default 6: width of seconds field.
REQ-002 The block SHALL have parameter P_MIN_BIT, default 6: width of minutes field.
REQ-003 The block SHALL have parameter P_HOUR_BIT, default 5: width of hours field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable; when 0, ticks are ignored.
REQ-007 The block SHALL have port i_tick, input, 1 bit: one-second pulse, one clk wide, from the upstream second generator.
REQ-008 The block SHALL have port i_load, input, 1 bit: single-cycle request to preset the time.
REQ-009 The block SHALL have ports i_sec, i_min and i_hour, input, P_SEC_BIT, P_MIN_BIT and P_HOUR_BIT bits: preset values, sampled when i_load=1.
REQ-010 The block SHALL have ports o_sec, o_min and o_hour, output, P_SEC_BIT, P_MIN_BIT and P_HOUR_BIT bits: current time, registered.
REQ-011 The block SHALL have ports o_min_tick, o_hour_tick and o_day_tick, output, 1 bit each: single-cycle carry pulses.
REQ-012 The block SHALL have port o_load_err, output, 1 bit: single-cycle pulse flagging a rejected preset.

Function
REQ-013 Legal ranges SHALL be: sec 0-59, min 0-59, hour 0-23.
REQ-014 When en=1 and i_tick=1 and i_load=0, o_sec SHALL increment by 1 at that clk edge; the new value is visible the next cycle (latency 1).
REQ-015 When o_sec=59 and an accepted tick occurs, o_sec SHALL become 0, o_min SHALL increment, and o_min_tick SHALL pulse high for exactly one cycle coincident with the update.
REQ-016 When o_sec=59, o_min=59 and an accepted tick occurs, o_min SHALL become 0, o_hour SHALL increment, and o_hour_tick SHALL pulse along with o_min_tick.
REQ-017 At 23:59:59 an accepted tick SHALL produce 00:00:00, with o_min_tick, o_hour_tick and o_day_tick all pulsed in the same cycle.
REQ-018 When en=0 or i_tick=0, time SHALL hold and all carry pulses SHALL be 0.
REQ-019 When i_load=1 and all preset fields are legal, the block SHALL load them at that edge, regardless of en; no carry pulses SHALL be generated.
REQ-020 When i_load=1 and any preset field is out of range, time SHALL be unchanged, o_load_err SHALL pulse 1 for one cycle, and a coincident tick SHALL be discarded.
REQ-021 A simultaneous i_load and accepted i_tick SHALL give priority to the load; the tick is dropped and not deferred.
REQ-022 Field arithmetic SHALL be unsigned and width-exact; the block SHALL never hold a value outside the legal range, including with non-default parameters wide enough for the range.
REQ-023 A tick held high for N consecutive cycles with en=1 SHALL advance time by N seconds.

Reset
REQ-024 Asserting reset SHALL immediately, without a clk edge, force o_sec=0, o_min=0, o_hour=0 and all pulse outputs to 0.
REQ-025 Reset asserted mid-count SHALL discard any in-flight tick or load.
REQ-026 After reset deasserts, the first accepted tick SHALL produce 00:00:01.

Verification
REQ-027 The bench SHALL cover: reset, then en=1 with 60 ticks -> o_sec 0..59 then 0, o_min=1, one o_min_tick pulse.
REQ-028 The bench SHALL cover: load 23:59:59, then 1 tick -> 00:00:00 with o_min_tick, o_hour_tick and o_day_tick all high for one cycle.
REQ-029 The bench SHALL cover: load 12:34:56 with a simultaneous tick -> 12:34:56, no pulses, no o_load_err.
REQ-030 The bench SHALL cover: load sec=60 (min=0, hour=0) from a state of 01:02:03 -> 01:02:03 held, o_load_err=1 for one cycle; likewise for hour=24.
REQ-031 The bench SHALL cover: en=0 with 10 ticks -> time unchanged; then en=1 with 1 tick -> +1 s.
REQ-032 The bench SHALL cover: reset asserted asynchronously between clk edges at 05:06:07 -> outputs go to 00:00:00 before the next edge.
